uart_rx_link: RTL and testbench

- Receive side and glue of the UART loopback path: RX bit recovery, byte hand-off to the external UART transmitter, and generation of the bit-rate strobe `clc` that paces that transmitter.
- Combines the former receiver (DEL), link controller (CONECT) and divider (DEL_COUNTER) into one single-clock block.
- Bytes received on RX are forwarded unchanged to the transmitter. The transmitter is external and signals completion on `priznak_end_transmitter`.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_link_if.sv | 31 +++
 rtl/uart_rx_core.sv | 123 ++++++++++++
 rtl/uart_rx_link.sv | 98 +++++++++
 tb/tb_uart_rx_link.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART receive/link path.
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 5;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_link_if.sv
// Serial input, transmitter handshake and status outputs of the UART link.
interface uart_rx_link_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);

    logic                 RX;
    logic                 priznak_end_transmitter;
    logic                 clc;
    logic [DATA_BITS-1:0] word_receiver;
    logic                 CONECT_PRIZNAC;
    logic                 ENABLE;
    logic                 ENABLE_DEL;
    logic [DATA_BITS-1:0] word_transmitter;
    logic                 TRANSMITTER_PRIZNAK;

    // master is the environment (line + transmitter), slave is the link block
    modport master (
        output RX, priznak_end_transmitter,
        input  clc, word_receiver, CONECT_PRIZNAC, ENABLE, ENABLE_DEL,
               word_transmitter, TRANSMITTER_PRIZNAK
    );

    modport slave (
        input  RX, priznak_end_transmitter,
        output clc, word_receiver, CONECT_PRIZNAC, ENABLE, ENABLE_DEL,
               word_transmitter, TRANSMITTER_PRIZNAK
    );

endinterface

// File: rtl/uart_rx_core.sv
// RX synchroniser and bit-recovery FSM; emits each correctly framed byte
// together with a one-cycle valid pulse.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] word,
    output logic                 word_valid,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] word_n;
    logic                 valid_n;

    // Synchroniser presets to the idle level so reset never fakes a start bit
    always_ff @(posedge clk) begin
        if (res) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= shreg_n;
            word       <= word_n;
            word_valid <= valid_n;
        end
    end

    // The detection cycle already counts as the first cycle of the start bit,
    // which centres every later sample in its bit cell.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        word_n  = word;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = CW'(1);
                    bit_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    cnt_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                    bit_n   = bit_idx + BW'(1);
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_n = '0;
                    if (rxs) begin
                        word_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/uart_rx_link.sv
// UART loopback glue: receiver, bit-rate strobe for the external transmitter
// and a one-byte holding stage between received and transmitted bytes.
module uart_rx_link
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input logic           clk,
    input logic           res,
    uart_rx_link_if.slave bus
);

    localparam int DW = $clog2(CLKS_PER_BIT);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    logic [DW-1:0]        div_cnt;
    logic [DATA_BITS-1:0] rx_word;
    logic                 rx_valid;
    logic                 rx_busy;

    logic [DATA_BITS-1:0] tx_word, tx_word_n;
    logic [DATA_BITS-1:0] hold, hold_n;
    logic                 tx_req, tx_req_n;
    logic                 hold_v, hold_v_n;
    logic                 link_ready;

    always_ff @(posedge clk) begin
        if (res || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_BITS   (DATA_BITS)
    ) u_core (
        .clk       (clk),
        .res       (res),
        .rx        (bus.RX),
        .word      (rx_word),
        .word_valid(rx_valid),
        .busy      (rx_busy)
    );

    // A finishing transmission is retired before a new byte is queued, so an
    // end pulse coinciding with a received byte never loses it.
    always_comb begin
        tx_word_n = tx_word;
        tx_req_n  = tx_req;
        hold_n    = hold;
        hold_v_n  = hold_v;
        if (bus.priznak_end_transmitter && tx_req) begin
            if (hold_v) begin
                tx_word_n = hold;
                hold_v_n  = 1'b0;
            end else begin
                tx_req_n = 1'b0;
            end
        end
        if (rx_valid) begin
            if (!tx_req_n) begin
                tx_word_n = rx_word;
                tx_req_n  = 1'b1;
            end else if (!hold_v_n) begin
                hold_n   = rx_word;
                hold_v_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            tx_word    <= '0;
            tx_req     <= 1'b0;
            hold       <= '0;
            hold_v     <= 1'b0;
            link_ready <= 1'b0;
        end else begin
            tx_word    <= tx_word_n;
            tx_req     <= tx_req_n;
            hold       <= hold_n;
            hold_v     <= hold_v_n;
            link_ready <= !tx_req_n && !hold_v_n;
        end
    end

    assign bus.clc                 = (div_cnt == DIV_LAST);
    assign bus.word_receiver       = rx_word;
    assign bus.CONECT_PRIZNAC      = rx_valid;
    assign bus.ENABLE              = rx_busy;
    assign bus.ENABLE_DEL          = link_ready;
    assign bus.word_transmitter    = tx_word;
    assign bus.TRANSMITTER_PRIZNAK = tx_req;

endmodule

// File: tb/tb_uart_rx_link.sv
// Scoreboard bench for uart_rx_link: frames are driven on RX, the link is
// modelled as a two-entry queue (transmitting byte plus held byte).
module tb_uart_rx_link;

    localparam int CLKS = 5;

    logic clk = 1'b0;
    logic res = 1'b1;

    uart_rx_link_if bus ();

    uart_rx_link #(
        .CLKS_PER_BIT(CLKS),
        .DATA_BITS   (8)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] link_q[$];
    logic [7:0] last_rx    = 8'h00;
    logic       pend_valid = 1'b0;
    logic [7:0] pend_byte  = 8'h00;
    logic [7:0] exp_byte;
    int         phase      = 0;
    logic       res_q      = 1'b1;
    logic       end_q      = 1'b0;
    bit         end_rand_en = 1'b0;

    // What the DUT saw at the last rising edge
    always @(posedge clk) begin
        res_q <= res;
        end_q <= bus.priznak_end_transmitter;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: reference link model is a queue holding at most two bytes
    always @(negedge clk) begin
        if (res_q) begin
            checkOutput("rst_clc", 32'(bus.clc), 32'(0));
            checkOutput("rst_word_receiver", 32'(bus.word_receiver), 32'(0));
            checkOutput("rst_conect", 32'(bus.CONECT_PRIZNAC), 32'(0));
            checkOutput("rst_enable", 32'(bus.ENABLE), 32'(0));
            checkOutput("rst_enable_del", 32'(bus.ENABLE_DEL), 32'(0));
            checkOutput("rst_word_transmitter", 32'(bus.word_transmitter), 32'(0));
            checkOutput("rst_tx_request", 32'(bus.TRANSMITTER_PRIZNAK), 32'(0));
            link_q.delete();
            exp_rx_q.delete();
            last_rx    = 8'h00;
            pend_valid = 1'b0;
            phase      = 0;
        end else begin
            phase++;
            checkOutput("clc", 32'(bus.clc), 32'((phase % CLKS) == CLKS - 1));
            if (end_q && link_q.size() > 0) void'(link_q.pop_front());
            if (pend_valid) begin
                if (link_q.size() < 2) link_q.push_back(pend_byte);
                pend_valid = 1'b0;
            end
            if (bus.CONECT_PRIZNAC) begin
                if (exp_rx_q.size() == 0) begin
                    checkOutput("rx_pulse_unexpected", 32'(bus.CONECT_PRIZNAC), 32'(0));
                end else begin
                    exp_byte = exp_rx_q.pop_front();
                    checkOutput("word_receiver", 32'(bus.word_receiver), 32'(exp_byte));
                    last_rx    = exp_byte;
                    pend_valid = 1'b1;
                    pend_byte  = exp_byte;
                end
            end else begin
                checkOutput("word_receiver_hold", 32'(bus.word_receiver), 32'(last_rx));
            end
            checkOutput("tx_request", 32'(bus.TRANSMITTER_PRIZNAK), 32'(link_q.size() > 0));
            checkOutput("enable_del", 32'(bus.ENABLE_DEL), 32'(link_q.size() == 0));
            if (link_q.size() > 0)
                checkOutput("word_transmitter", 32'(bus.word_transmitter), 32'(link_q[0]));
        end
    end

    // Randomly timed transmitter completions
    always @(posedge clk) begin
        if (end_rand_en) begin
            #2;
            bus.priznak_end_transmitter = ($urandom_range(0, 24) == 0);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok);
        bus.RX = 1'b0;
        waitCycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            bus.RX = data[i];
            if (i == 4) begin
                waitCycles(2);
                checkOutput("enable_in_frame", 32'(bus.ENABLE), 32'(1));
                waitCycles(CLKS - 2);
            end else begin
                waitCycles(CLKS);
            end
        end
        bus.RX = stop_ok;
        if (stop_ok) exp_rx_q.push_back(data);
        waitCycles(CLKS);
        bus.RX = 1'b1;
    endtask

    task automatic pulseEnd();
        bus.priznak_end_transmitter = 1'b1;
        waitCycles(1);
        bus.priznak_end_transmitter = 1'b0;
    endtask

    task automatic applyReset(input int n);
        res    = 1'b1;
        bus.RX = 1'b1;
        bus.priznak_end_transmitter = 1'b0;
        waitCycles(n);
        res = 1'b0;
    endtask

    task automatic sendGlitch();
        bus.RX = 1'b0;
        waitCycles(2);
        bus.RX = 1'b1;
        waitCycles(5);
        checkOutput("enable_after_glitch", 32'(bus.ENABLE), 32'(0));
    endtask

    task automatic resetMidFrame(input logic [7:0] data);
        bus.RX = 1'b0;
        waitCycles(CLKS);
        for (int i = 0; i < 3; i++) begin
            bus.RX = data[i];
            waitCycles(CLKS);
        end
        bus.RX = data[3];
        waitCycles(2);
        applyReset(1);
    endtask

    initial begin
        bus.RX = 1'b1;
        bus.priznak_end_transmitter = 1'b0;
        @(posedge clk);
        #2;
        applyReset(3);
        waitCycles(5);
        checkOutput("enable_idle", 32'(bus.ENABLE), 32'(0));

        applyStimulus(8'h55, 1'b1);
        waitCycles(10);
        checkOutput("enable_after_frame", 32'(bus.ENABLE), 32'(0));
        pulseEnd();
        waitCycles(5);

        applyStimulus(8'hFF, 1'b1);
        waitCycles(20);
        pulseEnd();
        waitCycles(480);
        checkOutput("enable_gap", 32'(bus.ENABLE), 32'(0));
        applyStimulus(8'h00, 1'b1);
        waitCycles(20);
        pulseEnd();
        waitCycles(5);

        sendGlitch();
        waitCycles(10);

        applyStimulus(8'hA5, 1'b0);
        waitCycles(10);
        applyStimulus(8'h3C, 1'b1);
        waitCycles(10);
        pulseEnd();
        waitCycles(5);

        applyStimulus(8'h11, 1'b1);
        waitCycles(3);
        applyStimulus(8'h22, 1'b1);
        waitCycles(3);
        applyStimulus(8'h33, 1'b1);
        waitCycles(10);
        pulseEnd();
        waitCycles(10);
        pulseEnd();
        waitCycles(5);

        resetMidFrame(8'h55);
        waitCycles(10);
        applyStimulus(8'h55, 1'b1);
        waitCycles(10);
        pulseEnd();
        waitCycles(5);

        end_rand_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
            waitCycles($urandom_range(3, 20));
        end
        end_rand_en = 1'b0;
        waitCycles(1);
        bus.priznak_end_transmitter = 1'b0;
        waitCycles(60);
        pulseEnd();
        waitCycles(3);
        pulseEnd();
        waitCycles(3);

        checkOutput("rx_queue_drained", 32'(exp_rx_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
